// File: rtl/mux_sel_arbiter_if.sv
// Request/select bundle between the four requesters, the arbiter and the
// downstream 4:1 mux. The arbiter sits on the slave side. The requesters and
// the mux observe it from the master side.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic       en;
  logic       s1;
  logic       s2;
  logic [3:0] gnt;
  logic       valid;

  modport master (
    output req,
    output en,
    input  s1,
    input  s2,
    input  gnt,
    input  valid
  );

  modport slave (
    input  req,
    input  en,
    output s1,
    output s2,
    output gnt,
    output valid
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux. It grants one requester at a
// time and registers the matching {s1,s2} select code. A hold counter bounds
// how long one requester can keep the mux while others are waiting.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_sel_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       gnt_q;
  logic             s1_q;
  logic             s2_q;
  logic             valid_q;

  logic [1:0]       cur_idx;
  logic [3:0]       pick_req;
  logic             others_pending;
  logic             hold_at_max;
  logic [1:0]       pick_idx;
  logic             take_new;
  logic             drop;

  // While a grant is active, {s1,s2} holds the granted index.
  assign cur_idx = {s1_q, s2_q};

  // The current holder is masked out, so a forced rotation moves to someone
  // else. In IDLE gnt_q is zero and every request competes.
  assign pick_req       = bus.req & ~gnt_q;
  assign others_pending = |pick_req;
  assign hold_at_max    = (hold_cnt == CNT_W'(MAX_HOLD));

  // Round-robin search starting just after the last winner (ptr).
  always_comb begin
    logic [1:0] idx1;
    logic [1:0] idx2;
    logic [1:0] idx3;
    idx1     = ptr + 2'd1;
    idx2     = ptr + 2'd2;
    idx3     = ptr + 2'd3;
    pick_idx = ptr;
    if (pick_req[idx1])
      pick_idx = idx1;
    else if (pick_req[idx2])
      pick_idx = idx2;
    else if (pick_req[idx3])
      pick_idx = idx3;
  end

  // Choose between keeping the grant, switching to a new winner, or releasing.
  always_comb begin
    take_new = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        take_new = bus.en && others_pending;
      end
      GRANT: begin
        if (!bus.req[cur_idx]) begin
          take_new = bus.en && others_pending;
          drop     = !(bus.en && others_pending);
        end else if (bus.en && others_pending && hold_at_max) begin
          take_new = 1'b1;
        end
      end
      default: begin
        take_new = 1'b0;
        drop     = 1'b0;
      end
    endcase
  end

  // Grant FSM. All outputs are registered, and s1/s2 only move on a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      hold_cnt <= '0;
      gnt_q    <= 4'b0000;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_new) begin
            state    <= GRANT;
            ptr      <= pick_idx;
            hold_cnt <= CNT_W'(1);
            gnt_q    <= 4'b0001 << pick_idx;
            s1_q     <= pick_idx[1];
            s2_q     <= pick_idx[0];
            valid_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (take_new) begin
            ptr      <= pick_idx;
            hold_cnt <= CNT_W'(1);
            gnt_q    <= 4'b0001 << pick_idx;
            s1_q     <= pick_idx[1];
            s2_q     <= pick_idx[0];
            valid_q  <= 1'b1;
          end else if (drop) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt_q    <= 4'b0000;
            valid_q  <= 1'b0;
          end else if (!hold_at_max) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gnt_q   <= 4'b0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = s1_q;
  assign bus.s2    = s2_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter. Three instances with MAX_HOLD = 8, 2 and 1 see
// the same stimulus and are checked against a per-instance round-robin model.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_v;
  logic       en_v;

  int total;
  int bad;

  mux_sel_arbiter_if bus8 ();
  mux_sel_arbiter_if bus2 ();
  mux_sel_arbiter_if bus1 ();

  assign bus8.req = req_v;
  assign bus8.en  = en_v;
  assign bus2.req = req_v;
  assign bus2.en  = en_v;
  assign bus1.req = req_v;
  assign bus1.en  = en_v;

  mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mux_sel_arbiter #(.MAX_HOLD(2), .CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Observed outputs packed as {valid, gnt[3:0], s1, s2}.
  logic [6:0] obs [3];
  assign obs[0] = {bus8.valid, bus8.gnt, bus8.s1, bus8.s2};
  assign obs[1] = {bus2.valid, bus2.gnt, bus2.s1, bus2.s2};
  assign obs[2] = {bus1.valid, bus1.gnt, bus1.s1, bus1.s2};

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: granted requester (-1 = none), cycles held,
  // last winner and last select code.
  int m_g   [3];
  int m_cnt [3];
  int m_ptr [3];
  int m_sel [3];
  int max_hold [3] = '{8, 2, 1};

  function automatic int rr_pick(logic [3:0] r, int p);
    for (int off = 1; off <= 4; off++) begin
      int i;
      i = (p + off) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_g[k]   = -1;
      m_cnt[k] = 0;
      m_ptr[k] = 3;
      m_sel[k] = 0;
    end
  endtask

  task automatic model_grant(int k, int w);
    m_g[k]   = w;
    m_ptr[k] = w;
    m_sel[k] = w;
    m_cnt[k] = 1;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int w;
      logic [3:0] others;
      if (m_g[k] < 0) begin
        w = rr_pick(req_v, m_ptr[k]);
        if (en_v && w >= 0) model_grant(k, w);
      end else begin
        others = req_v & ~(4'b0001 << m_g[k]);
        w = rr_pick(others, m_ptr[k]);
        if (!req_v[m_g[k]]) begin
          if (en_v && w >= 0) model_grant(k, w);
          else begin
            m_g[k]   = -1;
            m_cnt[k] = 0;
          end
        end else if (en_v && others != 4'b0000 && m_cnt[k] == max_hold[k]) begin
          model_grant(k, w);
        end else if (m_cnt[k] < max_hold[k]) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [6:0] model_out(int k);
    logic       v;
    logic [3:0] g;
    logic [1:0] s;
    v = (m_g[k] >= 0);
    g = v ? 4'(1 << m_g[k]) : 4'b0000;
    s = m_sel[k][1:0];
    return {v, g, s};
  endfunction

  function automatic logic [6:0] grant_vec(int idx);
    logic [1:0] s;
    s = idx[1:0];
    return {1'b1, 4'(1 << idx), s};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v = 4'b0000;
    en_v  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_v = 4'b0000;
    en_v  = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b0_0000_00) begin
        bad++;
        $display("[TB] FAIL reset_hold k=%0d got=%b want=%b", k, obs[k], 7'b0_0000_00);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    en_v  = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b0_0000_00) begin
        bad++;
        $display("[TB] FAIL idle_no_req k=%0d got=%b want=%b", k, obs[k], 7'b0_0000_00);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req_v = 4'b0100;
    en_v  = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b1_0100_10) begin
        bad++;
        $display("[TB] FAIL single_grant k=%0d got=%b want=%b", k, obs[k], 7'b1_0100_10);
      end
    end
    req_v = 4'b0000;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b0_0000_10) begin
        bad++;
        $display("[TB] FAIL single_release k=%0d got=%b want=%b", k, obs[k], 7'b0_0000_10);
      end
    end
  endtask

  task automatic test_fairness();
    int idx [3];
    do_reset();
    req_v = 4'b1111;
    en_v  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      idx[0] = (i < 8) ? 0 : 1;
      idx[1] = (i / 2) % 4;
      idx[2] = i % 4;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== grant_vec(idx[k])) begin
          bad++;
          $display("[TB] FAIL fairness k=%0d cyc=%0d got=%b want=%b", k, i, obs[k], grant_vec(idx[k]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_v = 4'b0010;
    en_v  = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b1_0010_01) begin
        bad++;
        $display("[TB] FAIL b2b_first k=%0d got=%b want=%b", k, obs[k], 7'b1_0010_01);
      end
    end
    req_v = 4'b1000;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b1_1000_11) begin
        bad++;
        $display("[TB] FAIL b2b_switch k=%0d got=%b want=%b", k, obs[k], 7'b1_1000_11);
      end
    end
  endtask

  task automatic test_en_gating();
    do_reset();
    req_v = 4'b0100;
    en_v  = 1'b1;
    tick();
    en_v  = 1'b0;
    req_v = 4'b1100;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b1_0100_10) begin
        bad++;
        $display("[TB] FAIL en_no_rotate k=%0d got=%b want=%b", k, obs[k], 7'b1_0100_10);
      end
    end
    req_v = 4'b1000;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b0_0000_10) begin
        bad++;
        $display("[TB] FAIL en_idle k=%0d got=%b want=%b", k, obs[k], 7'b0_0000_10);
      end
    end
    en_v = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b1_1000_11) begin
        bad++;
        $display("[TB] FAIL en_regrant k=%0d got=%b want=%b", k, obs[k], 7'b1_1000_11);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_v = 4'b1000;
    en_v  = 1'b1;
    repeat (5) tick();
    total++;
    if (obs[0] !== 7'b1_1000_11) begin
      bad++;
      $display("[TB] FAIL async_pre got=%b want=%b", obs[0], 7'b1_1000_11);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b0_0000_00) begin
        bad++;
        $display("[TB] FAIL async_clear k=%0d got=%b want=%b", k, obs[k], 7'b0_0000_00);
      end
    end
    req_v = 4'b1111;
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== 7'b1_0001_00) begin
        bad++;
        $display("[TB] FAIL async_first_a k=%0d got=%b want=%b", k, obs[k], 7'b1_0001_00);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req_v = 4'($urandom_range(0, 15));
      en_v = ($urandom_range(0, 7) != 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        want = model_out(k);
        total++;
        if (obs[k] !== want) begin
          bad++;
          $display("[TB] FAIL random k=%0d cyc=%0d req=%b en=%b got=%b want=%b",
                   k, i, req_v, en_v, obs[k], want);
        end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_v = 4'b0000;
    en_v  = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_en_gating();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin select generator that sits directly upstream of the 4:1 mux (Mux_4x1) and drives its s1/s2 select lines.
- Four requesters (a, b, c, d) raise request lines. The block grants one at a time, registers the matching select code, and holds it stable while the grant lasts.
- A hold limit bounds how long one requester can keep the mux when others are waiting, so no requester is starved.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one requester while another request is pending; legal range 1..(2**CNT_W - 1).
- CNT_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d.
- en  input  1  arbitration enable; when 0, no new grant is issued.
- s1  output  1  mux select MSB; equals granted index bit1.
- s2  output  1  mux select LSB; equals granted index bit0.
- gnt  output  4  one-hot grant, same bit order as req.
- valid  output  1  high while a grant is active and s1/s2 are meaningful.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Select encoding matches the downstream mux:
  - index0 → s1=0, s2=0 (a)
  - index1 → s1=0, s2=1 (b)
  - index2 → s1=1, s2=0 (c)
  - index3 → s1=1, s2=1 (d)
- All outputs are registered; there is no combinational path from req to the outputs.
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - s1=0, s2=0, gnt=4'b0000, valid=0.
  - Priority pointer ptr=3, so index0 has first priority.
  - hold_cnt=0, state=IDLE.
- Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins. On every new grant, ptr takes the winner's index.
- IDLE state:
  - If en=1 and req≠0 at a rising edge: on that edge register the winner; gnt=onehot(winner), s1/s2=winner code, valid=1, hold_cnt=1; go to GRANT.
  - Latency from req sampled to outputs is 1 cycle.
  - Otherwise stay in IDLE with valid=0 and gnt=0. s1/s2 keep their last value (no glitching on the mux select).
- GRANT state, evaluated each edge with g = granted index:
  - Release (req[g]=0):
    - If en=1 and another req bit is set: grant the next round-robin winner on the same edge (back-to-back, no bubble), hold_cnt=1.
    - Else go to IDLE: valid=0, gnt=0, s1/s2 held.
  - Forced rotation: req[g]=1, some other req bit set, en=1 and hold_cnt==MAX_HOLD → grant the next round-robin winner (excluding g unless it is the only requester), hold_cnt=1.
  - Otherwise keep the grant; hold_cnt increments and saturates at MAX_HOLD.
  - A sole requester holds the grant indefinitely.
- en=0 during GRANT: the current grant continues until release (no forced rotation). On release, go to IDLE and do not re-grant.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- Invariants:
  - gnt is always one-hot or zero.
  - valid == |gnt.
  - {s1,s2} == index of the gnt bit whenever valid=1.

Test Plan:
- Reset then idle: rst_n low, req=0000 → s1=0, s2=0, gnt=0000, valid=0. With rst_n high and req still 0000, all outputs stay unchanged.
- Single request: req=0100, en=1 → one edge later gnt=0100, s1=1, s2=0, valid=1. Drop req → next edge valid=0, gnt=0000, s1/s2 remain 1/0.
- Round-robin fairness: req=1111 held, MAX_HOLD=2 → grant order a, a, b, b, c, c, d, d, a… i.e. {s1,s2}=00,00,01,01,10,10,11,11,00.
- Back-to-back release: grant on b (req=0010). Then req=1000 on the same cycle b drops → next edge gnt=1000, s1=1, s2=1, valid stays 1 with no idle cycle.
- en gating: grant active on c with en=0 and req=1100. Drop req[2] → IDLE, valid=0, and no grant to d until en=1, which then gives gnt=1000 one edge later.
- Async reset mid-grant: grant on d with hold_cnt=5, pulse rst_n low between clock edges → outputs clear immediately to 0/0/0000/0. After release with req=1111, the first grant is a.
